// File: rtl/icache_decomp.sv
// icache_decomp: instruction-cache refill decompressor.
// A refill request is turned into a 16-bit codeword fetch from the codeword
// image. A dictionary codeword resolves through the on-chip dictionary. A raw
// codeword costs a second imem read from the raw-instruction table.
// Optional feature macro: CW_BUFFER_EN (one-entry codeword word buffer).
module icache_decomp #(
   parameter logic [31:0] CW_BASE  = 32'h0004_0000,
   parameter logic [31:0] RAW_BASE = 32'h0008_0000,
   parameter int          DICT_AW  = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [31:0]        req_addr,
   output logic [31:0]        req_rdata,
   output logic               mem_valid,
   input  logic               mem_ready,
   output logic [31:0]        mem_addr,
   input  logic [31:0]        mem_rdata,
   input  logic               dict_we,
   input  logic [DICT_AW-1:0] dict_addr,
   input  logic [31:0]        dict_wdata
);

   typedef enum logic [2:0] {IDLE, CW_FETCH, DECODE, RAW_FETCH, RESP} state_t;

   state_t      state, state_nxt;
   logic [31:0] dict [2**DICT_AW];
   logic        sel_hi;       // halfword select of the accepted request
   logic [31:0] cw_word;      // last fetched codeword word (doubles as buffer data)
   logic [15:0] cw;
   logic [31:0] req_cw_addr;
   logic [31:0] raw_addr;
   logic        cw_hit;
   logic        unused_addr_bits;

   // Two codewords per word: each codeword stands for one 4-byte instruction.
   assign req_cw_addr      = CW_BASE + {1'b0, req_addr[31:3], 2'b00};
   assign cw               = sel_hi ? cw_word[31:16] : cw_word[15:0];
   assign raw_addr         = RAW_BASE + {15'd0, cw[14:0], 2'b00};
   assign unused_addr_bits = ^req_addr[1:0];

`ifdef CW_BUFFER_EN
   logic        buf_valid;
   logic [31:0] buf_addr;

   assign cw_hit = buf_valid && (buf_addr == req_cw_addr);

   // Buffer tag: refreshed on every completed codeword fetch, cleared by reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         buf_valid <= 1'b0;
         buf_addr  <= '0;
      end else if (state == CW_FETCH && mem_ready) begin
         buf_valid <= 1'b1;
         buf_addr  <= mem_addr;
      end
   end
`else
   assign cw_hit = 1'b0;
`endif

   // Dictionary write port; a same-edge DECODE read sees the old entry.
   always_ff @(posedge clk) begin
      if (dict_we) dict[dict_addr] <= dict_wdata;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and handshake outputs; mem_valid only in the fetch states.
   always_comb begin
      state_nxt = state;
      mem_valid = 1'b0;
      req_ready = 1'b0;
      case (state)
         IDLE:      if (req_valid) state_nxt = cw_hit ? DECODE : CW_FETCH;
         CW_FETCH: begin
            mem_valid = 1'b1;
            if (mem_ready) state_nxt = DECODE;
         end
         DECODE:    state_nxt = cw[15] ? RESP : RAW_FETCH;
         RAW_FETCH: begin
            mem_valid = 1'b1;
            if (mem_ready) state_nxt = RESP;
         end
         RESP: begin
            req_ready = 1'b1;
            state_nxt = IDLE;
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // Datapath: imem address, captured codeword word and result register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_addr  <= '0;
         req_rdata <= '0;
         cw_word   <= '0;
         sel_hi    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               sel_hi <= req_addr[2];
               if (!cw_hit) mem_addr <= req_cw_addr;
            end
            CW_FETCH:  if (mem_ready) cw_word <= mem_rdata;
            DECODE: begin
               if (cw[15]) req_rdata <= dict[cw[DICT_AW-1:0]];
               else        mem_addr  <= raw_addr;
            end
            RAW_FETCH: if (mem_ready) req_rdata <= mem_rdata;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_decomp.sv
// tb_icache_decomp: randomized self-checking bench for icache_decomp.
// Reference model computes each refill from the address-mapping rules over a
// hashed imem image plus a shadow dictionary, and tracks the codeword buffer
// when CW_BUFFER_EN is defined.
module tb_icache_decomp;
   localparam logic [31:0] CW_BASE  = 32'h0004_0000;
   localparam logic [31:0] RAW_BASE = 32'h0008_0000;
   localparam int          DICT_AW  = 8;

   logic clk = 1'b0;
   logic resetn;
   logic req_valid, req_ready;
   logic [31:0] req_addr, req_rdata;
   logic mem_valid;
   logic mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic dict_we;
   logic [DICT_AW-1:0] dict_addr;
   logic [31:0] dict_wdata;

   // second instance for the address-wrap case; its imem never answers
   logic req_valid2, req_ready2, mem_valid2;
   logic [31:0] req_addr2, req_rdata2, mem_addr2;
   logic zero = 1'b0;
   logic [31:0] zero32 = '0;

   icache_decomp #(.CW_BASE(CW_BASE), .RAW_BASE(RAW_BASE), .DICT_AW(DICT_AW)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rdata(req_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .dict_we(dict_we), .dict_addr(dict_addr), .dict_wdata(dict_wdata));

   icache_decomp #(.CW_BASE(32'hFFFF_FFFC), .RAW_BASE(RAW_BASE), .DICT_AW(DICT_AW)) dut2 (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2), .req_rdata(req_rdata2),
      .mem_valid(mem_valid2), .mem_ready(zero), .mem_addr(mem_addr2), .mem_rdata(zero32),
      .dict_we(dict_we), .dict_addr(dict_addr), .dict_wdata(dict_wdata));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference state ----------------
   logic [31:0] ov [logic [31:0]];
   logic [31:0] dict_m [2**DICT_AW];
   bit          mbuf_v = 1'b0;
   logic [31:0] mbuf_a = '0;
   int n_chk = 0, n_err = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (ov.exists(a)) return ov[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- imem responder ----------------
   bit stall = 1'b0, late = 1'b0;
   int acc_n = 0, rdy_cyc = 0, dly = 0, prot_err = 0;
   logic [31:0] acc_log [1024];
   logic        prev_mv = 1'b0;
   logic [31:0] prev_addr = '0;

   always @(negedge clk) begin
      if (prev_mv && mem_valid && mem_addr !== prev_addr) prot_err++;
      prev_mv   = mem_valid;
      prev_addr = mem_addr;
      if (late) begin
         mem_ready = 1'b1;
         mem_rdata = 32'hDEAD_BEEF;
      end else if (mem_ready) begin
         mem_ready = 1'b0;
      end else if (mem_valid && !stall) begin
         if (dly == 0) begin
            mem_ready = 1'b1;
            mem_rdata = mem_word(mem_addr);
            if (acc_n < 1024) acc_log[acc_n] = mem_addr;
            acc_n++;
            rdy_cyc = cyc;
            dly = $urandom_range(0, 3);
         end else dly--;
      end
   end

   // ---------------- one refill against the model ----------------
   task automatic do_req(input logic [31:0] a);
      logic [31:0] cwa, w, exp, rawa;
      logic [15:0] cw;
      bit hit, got;
      int base, t0, nacc;
      @(negedge clk); #1;
      cwa  = CW_BASE + (a >> 3) * 4;
      w    = mem_word(cwa);
      cw   = a[2] ? w[31:16] : w[15:0];
      rawa = RAW_BASE + 32'(cw[14:0]) * 4;
      hit  = 1'b0;
`ifdef CW_BUFFER_EN
      hit = mbuf_v && (mbuf_a == cwa);
      if (!hit) begin mbuf_v = 1'b1; mbuf_a = cwa; end
`endif
      exp  = cw[15] ? dict_m[cw[DICT_AW-1:0]] : mem_word(rawa);
      base = acc_n;
      t0   = cyc;
      req_addr  = a;
      req_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk); #1;
         got = req_ready;
      end
      req_valid = 1'b0;
      if (!got) begin
         chk("req_timeout", 32'd0, 32'd1);
         return;
      end
      chk("rdata", req_rdata, exp);
      nacc = (hit ? 0 : 1) + (cw[15] ? 0 : 1);
      chk("imem_accesses", 32'(acc_n - base), 32'(nacc));
      if (!hit && acc_n - base >= 1) chk("cw_addr", acc_log[base], cwa);
      if (!cw[15] && acc_n - base == nacc) chk("raw_addr", acc_log[base + nacc - 1], rawa);
      if (hit && cw[15]) chk("hit_latency", 32'(cyc - t0), 32'd2);
      else               chk("latency", 32'(cyc - rdy_cyc), cw[15] ? 32'd2 : 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit got;
      int r0;
      logic [31:0] old;
      resetn = 1'b0; req_valid = 1'b0; req_addr = '0;
      req_valid2 = 1'b0; req_addr2 = '0;
      dict_we = 1'b0; dict_addr = '0; dict_wdata = '0;
      ov[32'h0004_0000] = 32'h0000_8005;
      ov[32'h0008_0000] = 32'h00A0_0093;
      ov[32'h0004_0004] = 32'h0000_8021;
      repeat (3) @(negedge clk); #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_req_rdata", req_rdata, 32'd0);
      chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      resetn = 1'b1;

      for (int i = 0; i < 2**DICT_AW; i++) begin
         @(negedge clk); #1;
         dict_we    = 1'b1;
         dict_addr  = DICT_AW'(i);
         dict_wdata = (i == 5) ? 32'h0000_0013 : $urandom;
         dict_m[i]  = dict_wdata;
      end
      @(negedge clk); #1;
      dict_we = 1'b0;

      // dictionary path then raw path on the same codeword word
      do_req(32'h0000_0000);
      do_req(32'h0000_0004);

      // dictionary write landing on the DECODE edge returns old data
      @(negedge clk); #1;
      r0  = acc_n;
      old = dict_m[8'h21];
      req_addr = 32'h0000_0008; req_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk); #1;
         got = (acc_n != r0);
      end
      if (!got) chk("coll_timeout", 32'd0, 32'd1);
      @(negedge clk); #1;
      dict_we = 1'b1; dict_addr = 8'h21; dict_wdata = ~old;
      @(negedge clk); #1;
      dict_we = 1'b0;
      dict_m[8'h21] = ~old;
      chk("coll_ready", {31'd0, req_ready}, 32'd1);
      chk("coll_old_data", req_rdata, old);
      req_valid = 1'b0;
`ifdef CW_BUFFER_EN
      mbuf_v = 1'b1; mbuf_a = 32'h0004_0004;
`endif
      do_req(32'h0000_0008);

      // randomized refills, mostly clustered so the buffer sees reuse
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_req((i % 4 == 0) ? $urandom : (32'($urandom_range(0, 63)) << 2));
      end

      // codeword address wraps modulo 2^32
      @(negedge clk); #1;
      req_addr2 = 32'h0000_0008; req_valid2 = 1'b1;
      repeat (2) @(negedge clk); #1;
      chk("wrap_mem_valid", {31'd0, mem_valid2}, 32'd1);
      chk("wrap_mem_addr", mem_addr2, 32'd0);
      req_valid2 = 1'b0;

      // reset during a stalled codeword fetch, then a stray mem_ready
      stall = 1'b1;
      @(negedge clk); #1;
      req_addr = 32'h0000_0010; req_valid = 1'b1;
      repeat (4) @(negedge clk); #1;
      chk("stall_mem_valid", {31'd0, mem_valid}, 32'd1);
      resetn = 1'b0; req_valid = 1'b0;
      @(negedge clk); #1;
      chk("rst_mid_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_mid_mem_addr", mem_addr, 32'd0);
      resetn = 1'b1;
      late = 1'b1;
      @(negedge clk); #1;
      late = 1'b0;
      stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         chk("late_req_ready", {31'd0, req_ready}, 32'd0);
         chk("late_mem_valid", {31'd0, mem_valid}, 32'd0);
      end
      mbuf_v = 1'b0;
      do_req(32'h0000_0010);
      do_req(32'h0000_0000);
      do_req(32'h0000_0004);

      chk("mem_addr_stable", 32'(prot_err), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
